// File: rtl/mac_operand_sequencer_if.sv
// mac_operand_sequencer_if: operand stream, MAC drive/return and result stream bundle
// slave  = sequencer side: takes in_*, mac_out, res_ready; drives in_ready, mac_*, res_*, busy
// master = environment side: line-buffer/weight fetch, MAC and result consumer
interface mac_operand_sequencer_if #(parameter int DW = 16);
  logic in_valid, in_ready;
  logic [DW-1:0] in_pixel, in_kernel;
  logic [DW-1:0] mac_pixel, mac_kernel, mac_out;
  logic mac_clr_n;
  logic res_valid, res_ready;
  logic [DW-1:0] res_data;
  logic busy;
  modport slave (
    input in_valid, in_pixel, in_kernel, mac_out, res_ready,
    output in_ready, mac_pixel, mac_kernel, mac_clr_n, res_valid, res_data, busy
  );
  modport master (
    output in_valid, in_pixel, in_kernel, mac_out, res_ready,
    input in_ready, mac_pixel, mac_kernel, mac_clr_n, res_valid, res_data, busy
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: feeds TAPS operand pairs to the MAC, captures and clears per window
// ports: clk, rst (sync, active-high), io (slave modport: operand stream in,
// registered MAC operands/clear out, mac_out in, result stream out, busy out)
module mac_operand_sequencer #(
  parameter int TAPS = 9,
  parameter int DW = 16,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  mac_operand_sequencer_if.slave io
);
  typedef enum logic [1:0] {FEED, DRAIN, CAPT, HOLD} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] tap_cnt;
  logic take, last;
  assign io.in_ready = state == FEED;
  assign take = io.in_valid && io.in_ready;
  assign last = tap_cnt == CNT_W'(TAPS - 1);
  assign io.busy = !(state == FEED && tap_cnt == '0);
  always_comb begin
    state_nx = state;
    state_nx = state == FEED ? (take && last ? DRAIN : FEED) :
               state == DRAIN ? CAPT :
               state == CAPT ? HOLD :
               (io.res_ready ? FEED : HOLD);
  end
  // Unaccepted cycles zero the operands so the always-adding MAC holds its sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FEED;
      tap_cnt <= '0;
      io.mac_pixel <= '0;
      io.mac_kernel <= '0;
      io.mac_clr_n <= 1'b0;
      io.res_valid <= 1'b0;
      io.res_data <= '0;
    end else begin
      state <= state_nx;
      tap_cnt <= take ? (last ? '0 : tap_cnt + 1'b1) : tap_cnt;
      io.mac_pixel <= take ? io.in_pixel : {DW{1'b0}};
      io.mac_kernel <= take ? io.in_kernel : {DW{1'b0}};
      io.mac_clr_n <= state_nx != HOLD;
      io.res_valid <= state_nx == HOLD;
      if (state == CAPT) io.res_data <= io.mac_out;
    end
  end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: directed and random checks against a window-sum reference model
module tb_mac_operand_sequencer;
  localparam int TAPS = 9;
  logic clk, rst;
  int total = 0, bad = 0;
  logic go = 0;
  mac_operand_sequencer_if #(.DW(16)) a();
  mac_operand_sequencer_if #(.DW(16)) b();
  mac_operand_sequencer #(.TAPS(TAPS), .DW(16), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .io(a.slave));
  mac_operand_sequencer #(.TAPS(1), .DW(16), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .io(b.slave));
  initial clk = 0;
  always #5 clk = ~clk;
  // MAC stand-in: accumulates pixel+kernel every edge, synchronous clear when mac_clr_n is low
  logic [15:0] acc_a, acc_b;
  always @(posedge clk) begin
    acc_a <= a.mac_clr_n ? acc_a + a.mac_pixel + a.mac_kernel : 16'h0;
    acc_b <= b.mac_clr_n ? acc_b + b.mac_pixel + b.mac_kernel : 16'h0;
  end
  assign a.mac_out = acc_a;
  assign b.mac_out = acc_b;
  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got_v, exp_v, $time);
    end
  endtask
  // Reference model: a window is TAPS accepted pairs; its result is the 16-bit sum of
  // pixel+kernel over the window. The result appears 2 edges after the last accept and
  // stays until consumed; no pairs are taken from window end until that handshake.
  int n, since;
  logic [15:0] sum, want, exp_pix, exp_ker;
  logic rst_d;
  logic [15:0] got[$], exp_q[$];
  always @(posedge clk) begin
    if (!rst && a.res_valid && a.res_ready) got.push_back(a.res_data);
    if (rst) begin
      n <= 0; sum <= 0; since <= -1; exp_pix <= 0; exp_ker <= 0; rst_d <= 1;
    end else begin
      rst_d <= 0;
      if (since < 0 && a.in_valid) begin
        exp_pix <= a.in_pixel;
        exp_ker <= a.in_kernel;
        if (n == TAPS - 1) begin
          want <= sum + a.in_pixel + a.in_kernel;
          since <= 0; n <= 0; sum <= 0;
        end else begin
          n <= n + 1;
          sum <= sum + a.in_pixel + a.in_kernel;
        end
      end else begin
        exp_pix <= 0;
        exp_ker <= 0;
        if (since >= 2 && a.res_ready) begin
          since <= -1;
          exp_q.push_back(want);
        end else if (since >= 0) since <= since + 1;
      end
    end
  end
  always @(negedge clk) if (go) begin
    chk("in_ready", a.in_ready, since < 0);
    chk("res_valid", a.res_valid, since >= 2);
    chk("mac_clr_n", a.mac_clr_n, !rst_d && !(since >= 2));
    chk("busy", a.busy, !(since < 0 && n == 0));
    chk("mac_pixel", a.mac_pixel, exp_pix);
    chk("mac_kernel", a.mac_kernel, exp_ker);
    if (since >= 2) chk("res_data", a.res_data, want);
    if (rst_d) chk("res_data_rst", a.res_data, 0);
  end
  task automatic drive(input logic v, input logic [15:0] p, input logic [15:0] k, input logic r);
    a.in_valid = v; a.in_pixel = p; a.in_kernel = k; a.res_ready = r;
    @(posedge clk);
    #2;
  endtask
  task automatic feed(input int cnt, input logic [15:0] p, input logic r);
    for (int i = 0; i < cnt; i++) drive(1, p, p, r);
  endtask
  task automatic expect_res(input string tag, input logic [15:0] e);
    for (int i = 0; i < 20 && got.size() == 0; i++) drive(0, 0, 0, 1);
    if (got.size() == 0) chk({tag, "_timeout"}, 0, 1);
    else chk(tag, got.pop_front(), e);
  endtask
  initial begin
    rst = 1;
    b.in_valid = 0; b.in_pixel = 0; b.in_kernel = 0; b.res_ready = 1;
    repeat (3) drive(0, 0, 0, 1);
    go = 1;
    rst = 0;
    drive(0, 0, 0, 1);
    feed(9, 16'h0400, 1);
    expect_res("t1_back_to_back", 16'h4800);
    for (int i = 0; i < 9; i++) begin
      drive(1, 16'h0400, 16'h0400, 1);
      drive(0, 16'h1234, 16'h5678, 1);
    end
    expect_res("t2_gaps", 16'h4800);
    feed(9, 16'h0400, 0);
    repeat (7) drive(0, 0, 0, 0);
    chk("t3_held", got.size(), 0);
    expect_res("t3_release", 16'h4800);
    feed(9, 16'h0400, 1);
    feed(12, 16'h0000, 1);
    expect_res("t4_first", 16'h4800);
    expect_res("t4_cleared", 16'h0000);
    feed(4, 16'h0400, 1);
    rst = 1;
    drive(0, 0, 0, 1);
    rst = 0;
    chk("t5_in_ready", a.in_ready, 1);
    chk("t5_busy", a.busy, 0);
    chk("t5_clr_n", a.mac_clr_n, 0);
    chk("t5_res_valid", a.res_valid, 0);
    feed(9, 16'h0400, 1);
    expect_res("t5_fresh", 16'h4800);
    feed(9, 16'h0400, 0);
    repeat (4) drive(0, 0, 0, 0);
    rst = 1;
    drive(0, 0, 0, 1);
    rst = 0;
    chk("hold_rst_valid", a.res_valid, 0);
    drive(0, 0, 0, 1);
    chk("hold_rst_dropped", got.size(), 0);
    got.delete();
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom % 150) == 0;
      drive(($urandom % 4) != 0, 16'($urandom), 16'($urandom), ($urandom % 3) != 0);
    end
    rst = 0;
    repeat (20) drive(0, 0, 0, 1);
    chk("rand_count", got.size(), exp_q.size());
    while (got.size() > 0 && exp_q.size() > 0) chk("rand_result", got.pop_front(), exp_q.pop_front());
    b.in_valid = 1; b.in_pixel = 16'h0400; b.in_kernel = 16'h0400;
    drive(0, 0, 0, 1);
    b.in_valid = 0;
    #1;
    chk("t6_drain_valid", b.res_valid, 0);
    chk("t6_drain_pixel", b.mac_pixel, 16'h0400);
    drive(0, 0, 0, 1);
    #1;
    chk("t6_capt_valid", b.res_valid, 0);
    chk("t6_capt_pixel", b.mac_pixel, 0);
    drive(0, 0, 0, 1);
    #1;
    chk("t6_res_valid", b.res_valid, 1);
    chk("t6_res_data", b.res_data, 16'h0800);
    chk("t6_clr_n", b.mac_clr_n, 0);
    drive(0, 0, 0, 1);
    #1;
    chk("t6_done_valid", b.res_valid, 0);
    chk("t6_in_ready", b.in_ready, 1);
    chk("t6_clr_n_up", b.mac_clr_n, 1);
    go = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
